// File: rtl/ps2_keycode_decoder_if.sv
// Bundles the PS/2 line inputs and the decoded key event outputs of ps2_keycode_decoder.
// dbg_state exposes the frame FSM state for checkers.
interface ps2_keycode_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       rx_error;
  logic [1:0] dbg_state;

  // key_valid is a one-cycle strobe with no ready: the consumer must take the
  // event in that cycle, or latch keycode/key_make/key_ext later since they hold.
  modport master (
    input  ps2_clk, ps2_dat,
    output keycode, key_make, key_ext, key_valid, rx_error, dbg_state
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  keycode, key_make, key_ext, key_valid, rx_error, dbg_state
  );
endinterface

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: sync, clock filter, 11-bit frame FSM, E0/F0 prefix folding.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the held key.
module ps2_keycode_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10_000
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_keycode_decoder_if.master bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t         state, next_state;
  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0]  filt_cnt;
  logic           clk_filt, clk_filt_d, fall;
  logic [TW-1:0]  tmo_cnt;
  logic           timeout;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg, byte_q;
  logic           par_bit;
  logic           shift_en, par_en, stop_en, stop_good;
  logic           byte_rdy, err_p;
  logic           ext_pend, brk_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk; clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat; dat_s2 <= dat_s1;
    end
  end

  // Filtered clock only follows clk_s2 after FILTER_LEN stable cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = clk_filt_d & ~clk_filt;
  assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || fall || state == IDLE) tmo_cnt <= '0;
    else if (!timeout)                  tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (fall && !dat_s2)                   next_state = DATA;
      DATA:   if (shift_en && bit_cnt == 3'd7)       next_state = PARITY;
      PARITY: if (par_en)                            next_state = STOP;
      STOP:   if (stop_en)                           next_state = IDLE;
      default:                                       next_state = IDLE;
    endcase
    if (timeout) next_state = IDLE;
  end

  always_comb begin
    shift_en  = (state == DATA)   && fall && !timeout;
    par_en    = (state == PARITY) && fall && !timeout;
    stop_en   = (state == STOP)   && fall && !timeout;
    stop_good = dat_s2 && (^{shreg, par_bit});
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      byte_q   <= '0;
      byte_rdy <= 1'b0;
      err_p    <= 1'b0;
    end else begin
      if (state == IDLE && fall && !dat_s2) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en)  par_bit <= dat_s2;
      if (stop_en) byte_q  <= shreg;
      byte_rdy <= stop_en && stop_good;
      err_p    <= stop_en && !stop_good;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held;
  logic       held_vld, held_match, repeat_make;
  assign held_match  = held_vld && (held == {ext_pend, byte_q});
  assign repeat_make = !brk_pend && held_match;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.keycode   <= '0;
      bus.key_make  <= 1'b0;
      bus.key_ext   <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.rx_error  <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held          <= '0;
      held_vld      <= 1'b0;
`endif
    end else begin
      bus.key_valid <= 1'b0;
      bus.rx_error  <= err_p | timeout;
      if (err_p || timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_vld <= 1'b0;
`endif
      end else if (byte_rdy) begin
        if (byte_q == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!repeat_make) begin
            bus.keycode   <= byte_q;
            bus.key_make  <= ~brk_pend;
            bus.key_ext   <= ext_pend;
            bus.key_valid <= 1'b1;
          end
          if (!brk_pend && !repeat_make) begin
            held     <= {ext_pend, byte_q};
            held_vld <= 1'b1;
          end else if (brk_pend && held_match) begin
            held_vld <= 1'b0;
          end
`else
          bus.keycode   <= byte_q;
          bus.key_make  <= ~brk_pend;
          bus.key_ext   <= ext_pend;
          bus.key_valid <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder; expected key events are queued before each frame.
// Honours PS2_TYPEMATIC_FILTER_EN for the auto-repeat expectations.
module tb_ps2_keycode_decoder;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2_keycode_decoder_if bus ();

  ps2_keycode_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every key_valid must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.key_valid || bus.rx_error) begin
        n_total++;
        assert (!(bus.key_valid && bus.rx_error)) n_pass++;
        else $error("FAIL strobe_overlap: observed %0b%0b expected not both", bus.key_valid, bus.rx_error);
      end
      if (bus.rx_error) err_cnt++;
      if (bus.key_valid) begin
        kv_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          $error("FAIL unexpected_event: observed %0h expected none", {bus.key_ext, bus.key_make, bus.keycode});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          assert ({bus.key_ext, bus.key_make, bus.keycode} === e) n_pass++;
          else $error("FAIL event: observed %0h expected %0h", {bus.key_ext, bus.key_make, bus.keycode}, e);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.ps2_dat = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good_parity ? ~(^b) : (^b));
    send_bit(1'b1);
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    int kv0, err0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_keycode", bus.keycode, 0);
    chk("rst_make", bus.key_make, 0);
    chk("rst_ext", bus.key_ext, 0);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_error", bus.rx_error, 0);
    chk("rst_state", bus.dbg_state, 0);

    // Extended make
    send_frame(8'hE0, 1'b1);
    chk("e0_no_event", kv_cnt, 0);
    exp_q.push_back({1'b1, 1'b1, 8'h6B});
    send_frame(8'h6B, 1'b1);
    chk("ext_make_cnt", kv_cnt, 1);
    chk("ext_make_code", bus.keycode, 8'h6B);
    chk("ext_make_make", bus.key_make, 1);
    chk("ext_make_ext", bus.key_ext, 1);

    // Extended break then plain make
    exp_q.push_back({1'b1, 1'b0, 8'h74});
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h74, 1'b1);
    chk("ext_brk_cnt", kv_cnt, 2);
    chk("ext_brk_code", bus.keycode, 8'h74);
    chk("ext_brk_make", bus.key_make, 0);
    chk("ext_brk_ext", bus.key_ext, 1);
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    send_frame(8'h1C, 1'b1);
    chk("plain_code", bus.keycode, 8'h1C);
    chk("plain_make", bus.key_make, 1);
    chk("plain_ext", bus.key_ext, 0);

    // Parity error after a break prefix: error must also drop the prefix
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);
    chk("par_err_cnt", err_cnt, 1);
    chk("par_no_event", kv_cnt, 3);
    chk("par_hold_code", bus.keycode, 8'h1C);
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    send_frame(8'h1C, 1'b1);
    chk("par_recover_cnt", kv_cnt, 4);
    chk("par_recover_make", bus.key_make, 1);

    // Timeout mid-frame after an E0 prefix
    send_frame(8'hE0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (TIMEOUT + 200) @(negedge clk);
    chk("tmo_err_cnt", err_cnt, 2);
    chk("tmo_state", bus.dbg_state, 0);
    exp_q.push_back({1'b0, 1'b1, 8'h75});
    send_frame(8'h75, 1'b1);
    chk("tmo_code", bus.keycode, 8'h75);
    chk("tmo_ext_cleared", bus.key_ext, 0);

    // 3-cycle glitch with data low must not start a frame
    bus.ps2_dat = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_state", bus.dbg_state, 0);
    bus.ps2_dat = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    chk("glitch_no_err", err_cnt, 2);

    // Reset after 5 data bits
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_code", bus.keycode, 0);
    chk("mid_rst_make", bus.key_make, 0);
    chk("mid_rst_ext", bus.key_ext, 0);
    chk("mid_rst_state", bus.dbg_state, 0);
    repeat (4 * HALF) @(negedge clk);
    exp_q.push_back({1'b0, 1'b1, 8'h6B});
    send_frame(8'h6B, 1'b1);
    chk("post_rst_code", bus.keycode, 8'h6B);
    chk("post_rst_make", bus.key_make, 1);

    // Auto-repeat: E0 75 x3 then E0 F0 75
    kv0 = kv_cnt;
    err0 = err_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'h75});
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    exp_q.push_back({1'b1, 1'b1, 8'h75});
`endif
    exp_q.push_back({1'b1, 1'b0, 8'h75});
    for (int r = 0; r < 3; r++) begin
      send_frame(8'hE0, 1'b1);
      send_frame(8'h75, 1'b1);
    end
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h75, 1'b1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_cnt", kv_cnt - kv0, 2);
`else
    chk("typematic_cnt", kv_cnt - kv0, 4);
`endif
    chk("typematic_no_err", err_cnt - err0, 0);
    chk("typematic_make", bus.key_make, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
